// File: rtl/range_frame_decoder.sv
// Rangefinder frame decoder: hunts for a header byte, then checks the payload character set,
// the additive checksum and inter-byte timing, and outputs the distance as packed BCD.
module range_frame_decoder #(
    parameter logic [7:0]  HEADER    = 8'h80,
    parameter int unsigned FRAME_LEN = 13,
    parameter int unsigned DIGITS    = 5,
    parameter int unsigned TIMEOUT   = 50000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  RxEn,
    input  logic [7:0]            RxData,
    output logic                  OutEn,
    output logic [4*DIGITS-1:0]   DistOut,
    output logic                  ErrEn,
    output logic [1:0]            ErrCode,
    output logic [15:0]           GoodCnt
);

    localparam int unsigned IDX_W  = $clog2(FRAME_LEN);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 3);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StHunt, StPayload, StCheck} state_e;

    state_e                r_state, w_state_d;
    logic [7:0]            r_sum, w_sum_d;
    logic [IDX_W-1:0]      r_idx, w_idx_d;
    logic [IDLE_W-1:0]     r_idle, w_idle_d;
    logic [4*DIGITS-1:0]   r_shift, w_shift_d;
    logic                  r_out_en;
    logic [4*DIGITS-1:0]   r_dist;
    logic                  r_err_en;
    logic [1:0]            r_err_code;
    logic [15:0]           r_good_cnt;

    logic                  w_is_header;
    logic                  w_is_digit;
    logic                  w_is_sep;
    logic                  w_timeout;
    logic                  w_good;
    logic                  w_err_en;
    logic [1:0]            w_err_code;

    assign w_is_header = (RxData == HEADER);
    assign w_is_digit  = (RxData >= 8'h30) && (RxData <= 8'h39);
    assign w_is_sep    = (RxData == 8'h2E) || (RxData == 8'h20);
    // A byte in the would-be timeout cycle wins, hence the !RxEn term.
    assign w_timeout   = (r_state != StHunt) && !RxEn && (r_idle == IDLE_LAST);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= StHunt;
            r_sum      <= '0;
            r_idx      <= '0;
            r_idle     <= '0;
            r_shift    <= '0;
            r_out_en   <= 1'b0;
            r_dist     <= '0;
            r_err_en   <= 1'b0;
            r_err_code <= 2'd0;
            r_good_cnt <= '0;
        end else begin
            r_state    <= w_state_d;
            r_sum      <= w_sum_d;
            r_idx      <= w_idx_d;
            r_idle     <= w_idle_d;
            r_shift    <= w_shift_d;
            r_out_en   <= w_good;
            r_err_en   <= w_err_en;
            if (w_err_en) begin
                r_err_code <= w_err_code;
            end
            if (w_good) begin
                r_dist     <= r_shift;
                r_good_cnt <= r_good_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_sum_d   = r_sum;
        w_idx_d   = r_idx;
        w_idle_d  = '0;
        w_shift_d = r_shift;
        unique case (r_state)
            StHunt: begin
                if (RxEn && w_is_header) begin
                    w_state_d = StPayload;
                    w_sum_d   = HEADER;
                    w_idx_d   = '0;
                    w_shift_d = '0;
                end
            end
            StPayload: begin
                if (RxEn) begin
                    w_sum_d = r_sum + RxData;
                    w_idx_d = r_idx + 1'b1;
                    if (w_is_digit) begin
                        w_shift_d[3:0] = RxData[3:0];
                        for (int unsigned i = 1; i < DIGITS; i++) begin
                            w_shift_d[4*i +: 4] = r_shift[4*(i-1) +: 4];
                        end
                    end
                    if (!w_is_digit && !w_is_sep) begin
                        w_state_d = StHunt;
                    end else if (r_idx == IDX_LAST) begin
                        w_state_d = StCheck;
                    end
                end else if (w_timeout) begin
                    w_state_d = StHunt;
                end else begin
                    w_idle_d = r_idle + 1'b1;
                end
            end
            StCheck: begin
                if (RxEn || w_timeout) begin
                    w_state_d = StHunt;
                end else begin
                    w_idle_d = r_idle + 1'b1;
                end
            end
            default: w_state_d = StHunt;
        endcase
    end

    always_comb begin
        w_good     = 1'b0;
        w_err_en   = 1'b0;
        w_err_code = 2'd0;
        if (w_timeout) begin
            w_err_en   = 1'b1;
            w_err_code = 2'd3;
        end else if (RxEn && (r_state == StPayload) && !w_is_digit && !w_is_sep) begin
            w_err_en   = 1'b1;
            w_err_code = 2'd2;
        end else if (RxEn && (r_state == StCheck)) begin
            if (RxData == r_sum) begin
                w_good = 1'b1;
            end else begin
                w_err_en   = 1'b1;
                w_err_code = 2'd1;
            end
        end
    end

    assign OutEn   = r_out_en;
    assign DistOut = r_dist;
    assign ErrEn   = r_err_en;
    assign ErrCode = r_err_code;
    assign GoodCnt = r_good_cnt;

endmodule
